// File: rtl/button_debouncer_pkg.sv
//==============================================================================
// Module      : button_debouncer_pkg
// Description : Shared helpers for the button debouncer (cycle-count derivation)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package button_debouncer_pkg;

    localparam int c_HZ_PER_MHZ = 1000000;

    // Clock is an integer number of MHz, so cycles-per-microsecond is exact.
    function automatic int calc_debounce_cycles(input int freq_hz, input int time_us);
        return (freq_hz / c_HZ_PER_MHZ) * time_us;
    endfunction

endpackage : button_debouncer_pkg

`default_nettype wire

// File: rtl/debounce_channel.sv
//==============================================================================
// Module      : debounce_channel
// Description : One channel: synchronizer, polarity fix, stability counter,
//               registered level and single-cycle rise/fall pulses
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debounce_channel #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 3,
    parameter logic INVERT          = 1'b0
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   cond_w;

    // Chain resets to the inactive pad level so cond starts at 0.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= {SYNC_STAGES{INVERT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign cond_w = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_comb begin
        count_d = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (cond_w != level_q) begin
            if (count_q == c_LAST) begin
                level_d = cond_w;
                rise_d  = cond_w;
                fall_d  = ~cond_w;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/button_debouncer.sv
//==============================================================================
// Module      : button_debouncer
// Description : Multi-channel pad conditioner producing debounced levels and
//               registered rise/fall pulses
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int                    NUM_INPUTS       = 2,
    parameter int                    CLOCK_FREQUENCY  = 12000000,
    parameter int                    DEBOUNCE_TIME_US = 10000,
    parameter int                    SYNC_STAGES      = 2,
    parameter logic [NUM_INPUTS-1:0] INVERT_MASK      = {NUM_INPUTS{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] level_out,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse
);

    localparam int DEBOUNCE_CYCLES = calc_debounce_cycles(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_channel
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .INVERT          (INVERT_MASK[g])
        ) u_channel (
            .clock_i   (clock),
            .reset_n_i (reset_n),
            .raw_i     (raw_in[g]),
            .level_o   (level_out[g]),
            .rise_o    (rise_pulse[g]),
            .fall_o    (fall_pulse[g])
        );
    end

endmodule : button_debouncer

`default_nettype wire

// File: tb/tb_button_debouncer.sv
//==============================================================================
// Module      : tb_button_debouncer
// Description : Directed self-checking bench for button_debouncer
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_button_debouncer;

    logic       clock;
    logic       reset_n;
    logic [1:0] raw_in;
    logic [1:0] level_out;
    logic [1:0] rise_pulse;
    logic [1:0] fall_pulse;

    int vectors;
    int miscompares;

    button_debouncer #(
        .NUM_INPUTS       (2),
        .CLOCK_FREQUENCY  (1000000),
        .DEBOUNCE_TIME_US (4),
        .SYNC_STAGES      (2),
        .INVERT_MASK      (2'b10)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        raw_in  = 2'b10;
        reset_n = 1'b0;
        #12;
        vectors++;
        if ({level_out, rise_pulse, fall_pulse} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_values: got %b required 000000", {level_out, rise_pulse, fall_pulse});
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clock); #1;
            vectors++;
            if ({level_out, rise_pulse, fall_pulse} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_quiet edge %0d: got %b required 000000", e, {level_out, rise_pulse, fall_pulse});
            end
        end
    endtask

    task automatic test_clean_press();
        raw_in[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            vectors++;
            if ({level_out, rise_pulse, fall_pulse} !== {1'b0, (e >= 6), 1'b0, (e == 6), 2'b00}) begin
                miscompares++;
                $display("FAIL press edge %0d: got %b required %b", e, {level_out, rise_pulse, fall_pulse},
                         {1'b0, (e >= 6), 1'b0, (e == 6), 2'b00});
            end
        end
        raw_in[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            vectors++;
            if ({level_out, rise_pulse, fall_pulse} !== {1'b0, (e < 6), 2'b00, 1'b0, (e == 6)}) begin
                miscompares++;
                $display("FAIL release edge %0d: got %b required %b", e, {level_out, rise_pulse, fall_pulse},
                         {1'b0, (e < 6), 2'b00, 1'b0, (e == 6)});
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pattern;
        pattern = 7'b1110111;
        // Drive k happens just after edge k; final rising drive is k=4, so rise at edge 10.
        for (int k = 0; k <= 11; k++) begin
            raw_in[0] = (k < 7) ? pattern[6-k] : 1'b1;
            @(posedge clock); #1;
            vectors++;
            if ({level_out[0], rise_pulse[0], fall_pulse[0]} !== {(k + 1 >= 10), (k + 1 == 10), 1'b0}) begin
                miscompares++;
                $display("FAIL bounce edge %0d: got %b required %b", k + 1,
                         {level_out[0], rise_pulse[0], fall_pulse[0]}, {(k + 1 >= 10), (k + 1 == 10), 1'b0});
            end
        end
        raw_in[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            vectors++;
            if (fall_pulse[0] !== (e == 6)) begin
                miscompares++;
                $display("FAIL bounce_release edge %0d: got %b required %b", e, fall_pulse[0], (e == 6));
            end
        end
    endtask

    task automatic test_inverted();
        raw_in[1] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            vectors++;
            if ({level_out, rise_pulse, fall_pulse} !== {(e >= 6), 1'b0, (e == 6), 1'b0, 2'b00}) begin
                miscompares++;
                $display("FAIL inverted edge %0d: got %b required %b", e, {level_out, rise_pulse, fall_pulse},
                         {(e >= 6), 1'b0, (e == 6), 1'b0, 2'b00});
            end
        end
    endtask

    task automatic test_simultaneous();
        // ch0 rises while active-low ch1 is released and falls.
        raw_in = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            vectors++;
            if ({level_out, rise_pulse, fall_pulse} !== {(e < 6), (e >= 6), 1'b0, (e == 6), (e == 6), 1'b0}) begin
                miscompares++;
                $display("FAIL simultaneous edge %0d: got %b required %b", e, {level_out, rise_pulse, fall_pulse},
                         {(e < 6), (e >= 6), 1'b0, (e == 6), (e == 6), 1'b0});
            end
            vectors++;
            if ((rise_pulse & fall_pulse) !== 2'b00) begin
                miscompares++;
                $display("FAIL rise_fall_exclusive edge %0d: got %b required 00", e, rise_pulse & fall_pulse);
            end
        end
        raw_in = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
        end
        vectors++;
        if ({level_out, rise_pulse, fall_pulse} !== 6'b0) begin
            miscompares++;
            $display("FAIL simultaneous_return: got %b required 000000", {level_out, rise_pulse, fall_pulse});
        end
    endtask

    task automatic test_reset_mid_count();
        raw_in[0] = 1'b1;
        // Count reaches 2 after edge 4.
        for (int e = 1; e <= 4; e++) begin
            @(posedge clock); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({level_out, rise_pulse, fall_pulse} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_mid_assert: got %b required 000000", {level_out, rise_pulse, fall_pulse});
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            vectors++;
            if ({level_out, rise_pulse, fall_pulse} !== {1'b0, (e >= 6), 1'b0, (e == 6), 2'b00}) begin
                miscompares++;
                $display("FAIL reset_mid_release edge %0d: got %b required %b", e,
                         {level_out, rise_pulse, fall_pulse}, {1'b0, (e >= 6), 1'b0, (e == 6), 2'b00});
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        raw_in      = 2'b10;
        reset_n     = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_inverted();
        test_simultaneous();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_button_debouncer

`default_nettype wire
